// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 compression engine: one 512-bit block per job, ROUNDS_PER_CYCLE
// rounds per clock, chaining across blocks through internal H registers.
module sha256_block_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first_blk,
  input  logic [511:0] blk_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [1:0]   state_dbg
);

  localparam int NUM_ROUND_CYC = 64 / ROUNDS_PER_CYCLE;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  state_t         state_q, state_d;
  logic [6:0]     t;
  logic [255:0]   st;
  logic [255:0]   hreg;
  logic           first_q;
  logic [31:0]    w [0:15];
  logic [31:0]    w_nxt [0:15];
  logic [255:0]   round_out;
  logic [255:0]   new_h;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // The window always holds W[t..t+15]; it is extended by R words so each
  // unrolled round finds its schedule word at ext[j].
  always_comb begin : round_logic
    logic [31:0]  ext [0:15+ROUNDS_PER_CYCLE];
    logic [255:0] s;
    for (int k = 0; k < 16; k++) ext[k] = w[k];
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      ext[16+j] = (ror(ext[14+j], 17) ^ ror(ext[14+j], 19) ^ (ext[14+j] >> 10)) + ext[9+j]
                + (ror(ext[1+j], 7) ^ ror(ext[1+j], 18) ^ (ext[1+j] >> 3)) + ext[j];
    end
    s = st;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) s = sha_round(s, K[6'(t) + 6'(j)], ext[j]);
    round_out = s;
    for (int k = 0; k < 16; k++) w_nxt[k] = ext[k+ROUNDS_PER_CYCLE];
  end

  always_comb begin
    new_h = '0;
    for (int i = 0; i < 8; i++)
      new_h[255-32*i -: 32] = (first_q ? IV[255-32*i -: 32] : hreg[255-32*i -: 32]) + st[255-32*i -: 32];
  end

  // start is accepted on any edge where the engine is idle (busy low);
  // there is no back-pressure beyond that and no queueing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (t == 7'(64 - ROUNDS_PER_CYCLE)) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      digest  <= '0;
      hreg    <= IV;
      t       <= '0;
      st      <= '0;
      first_q <= 1'b0;
      for (int k = 0; k < 16; k++) w[k] <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          for (int k = 0; k < 16; k++) w[k] <= blk_in[511-32*k -: 32];
          first_q <= first_blk;
          st      <= first_blk ? IV : hreg;
          t       <= '0;
        end
        S_ROUND: begin
          st <= round_out;
          for (int k = 0; k < 16; k++) w[k] <= w_nxt[k];
          t  <= t + 7'(ROUNDS_PER_CYCLE);
        end
        S_FINAL: begin
          hreg   <= new_h;
          digest <= new_h;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Bench for sha256_block_engine: four lanes (R=1,2,4,8) each run directed jobs
// against a transaction-level SHA-256 model and hand-computed digests.
module tb_sha256_block_engine;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] B1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2_BLK = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression with a full 64-word message schedule.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wv [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) wv[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      wv[i] = (ror(wv[i-2], 17) ^ ror(wv[i-2], 19) ^ (wv[i-2] >> 10)) + wv[i-7]
            + (ror(wv[i-15], 7) ^ ror(wv[i-15], 18) ^ (wv[i-15] >> 3)) + wv[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + KT[i] + wv[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return res;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : lane
    localparam int R = 1 << gi;
    localparam int N = 64 / R;

    logic         rst, start, first_blk;
    logic [511:0] blk_in;
    logic         busy, done;
    logic [255:0] digest;
    logic [1:0]   state_dbg;
    logic         fin;
    int           lat;

    logic         m_ok = 1'b0;
    logic         m_active, m_done;
    logic [255:0] m_h, m_dig, m_res;
    int           cyc = 0;
    int           m_fin;

    sha256_block_engine #(.ROUNDS_PER_CYCLE(R)) dut (
      .clk(clk), .rst(rst), .start(start), .first_blk(first_blk), .blk_in(blk_in),
      .busy(busy), .done(done), .digest(digest), .state_dbg(state_dbg));

    // Transaction model: a job accepted at edge c completes at edge c+N+1.
    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
        m_ok <= 1'b1; m_active <= 1'b0; m_done <= 1'b0; m_dig <= '0; m_h <= IV;
      end else begin
        m_done <= 1'b0;
        if (m_active && cyc == m_fin) begin
          m_h <= m_res; m_dig <= m_res; m_done <= 1'b1; m_active <= 1'b0;
        end else if (!m_active && start) begin
          m_res    <= sha_compress(first_blk ? IV : m_h, blk_in);
          m_fin    <= cyc + N + 1;
          m_active <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (m_ok) begin
        chk($sformatf("R%0d_busy_t%0d", R, cyc), 256'(busy), 256'(m_active));
        chk($sformatf("R%0d_done_t%0d", R, cyc), 256'(done), 256'(m_done));
        chk($sformatf("R%0d_digest_t%0d", R, cyc), digest, m_dig);
      end
    end

    task automatic run_job(input logic fb, input logic [511:0] blk);
      first_blk = fb;
      blk_in    = blk;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      first_blk = 1'($urandom_range(0, 1));
      blk_in    = {16{$urandom()}};
      lat = 0;
      while (!done && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL R%0d_done_timeout: actual no done within %0d cycles required %0d", R, lat, N + 1);
      end
    endtask

    initial begin
      fin = 1'b0; rst = 1'b1; start = 1'b0; first_blk = 1'b0; blk_in = '0;
      repeat (2) @(negedge clk);
      chk($sformatf("R%0d_reset_busy", R), 256'(busy), 256'(0));
      chk($sformatf("R%0d_reset_done", R), 256'(done), 256'(0));
      chk($sformatf("R%0d_reset_digest", R), digest, '0);
      rst = 1'b0;

      run_job(1'b1, ABC_BLK);
      chk($sformatf("R%0d_abc_latency", R), 256'(lat), 256'(N + 1));
      chk($sformatf("R%0d_abc_digest", R), digest, ABC_DIG);

      run_job(1'b1, EMPTY_BLK);
      chk($sformatf("R%0d_empty_latency", R), 256'(lat), 256'(N + 1));
      chk($sformatf("R%0d_empty_digest", R), digest, EMPTY_DIG);

      run_job(1'b1, B1_BLK);
      run_job(1'b0, B2_BLK);
      chk($sformatf("R%0d_b2b_latency", R), 256'(lat), 256'(N + 1));
      chk($sformatf("R%0d_two_block_digest", R), digest, TWO_DIG);

      first_blk = 1'b1; blk_in = ABC_BLK; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10 / R + 1) @(negedge clk);
      first_blk = 1'b1; blk_in = EMPTY_BLK; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("R%0d_ignored_start_digest", R), digest, ABC_DIG);

      first_blk = 1'b1; blk_in = ABC_BLK; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30 / R) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("R%0d_midrst_busy", R), 256'(busy), 256'(0));
      chk($sformatf("R%0d_midrst_done", R), 256'(done), 256'(0));
      chk($sformatf("R%0d_midrst_digest", R), digest, '0);
      run_job(1'b0, ABC_BLK);
      chk($sformatf("R%0d_after_rst_digest", R), digest, ABC_DIG);
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    chk("model_abc", sha_compress(IV, ABC_BLK), ABC_DIG);
    chk("model_empty", sha_compress(IV, EMPTY_BLK), EMPTY_DIG);
    chk("model_two_block", sha_compress(sha_compress(IV, B1_BLK), B2_BLK), TWO_DIG);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin) break;
    end
    if (!(lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin)) begin
      n_checks++;
      n_fail++;
      $display("FAIL lanes_finish: actual unfinished required all four lanes finished");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
